// File: rtl/cla_multicycle_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit carry-lookahead slice per RUN cycle,
// with the carry registered between slices and the result loaded on entry to DONE.
module cla_multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_acc;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_s;
  logic [SLICE:0]   w_c;
  logic [WIDTH-1:0] w_acc_next;
  int               w_base;

  // Lookahead slice selected by r_idx; w_acc_next is the partial sum with this slice merged in.
  always_comb begin
    w_base     = int'(r_idx) * SLICE;
    w_sa       = r_a[w_base +: SLICE];
    w_sb       = r_b[w_base +: SLICE];
    w_g        = w_sa & w_sb;
    w_p        = w_sa | w_sb;
    w_c        = '0;
    w_c[0]     = r_carry;
    w_s        = '0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      w_s[i]   = w_sa[i] ^ w_sb[i] ^ w_c[i];
    end
    w_acc_next = r_acc;
    w_acc_next[w_base +: SLICE] = w_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1, so Cin is dropped in that mode.
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? 1'b1 : Cin;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_c[SLICE];
          if (r_idx == LAST) begin
            S       <= w_acc_next;
            Cout    <= w_c[SLICE];
            Ovf     <= w_c[SLICE] ^ w_c[SLICE-1];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multicycle_adder.sv
// Bench for cla_multicycle_adder (WIDTH=16, SLICE=4): a transaction-level model
// checked every cycle, plus directed cases with hand-computed results.
module tb_cla_multicycle_adder;

  localparam int W  = 16;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Sub = 1'b0;
  logic [W-1:0] S;
  logic         Cout, Ovf, busy, done;

  int vectors = 0;
  int errors  = 0;

  cla_multicycle_adder #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .S(S), .Cout(Cout), .Ovf(Ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Result as {Ovf, Cout, S} from plain arithmetic; overflow from operand/result signs.
  function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         ov;
    be = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  // Transaction model: countdown of remaining cycles, pending result, output copy.
  int           m_left = 0;
  logic         m_busy = 1'b0, m_done = 1'b0;
  logic [W+1:0] m_pend = '0, m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_pend = '0; m_res = '0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = calc(A, B, Cin, Sub);
        m_busy = 1'b1;
        m_left = NS;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    check("cycle {Ovf,Cout,S,busy,done}", {12'd0, Ovf, Cout, S, busy, done},
          {12'd0, m_res[W+1], m_res[W], m_res[W-1:0], m_busy, m_done});

  // Issue one op; returns at the negedge where done is seen, with busy-cycle count.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                    input logic sub, output int bc);
    @(posedge clk); #1;
    A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc);
  endtask

  task automatic wait_done(output int bc);
    bit got;
    bc = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) got = 1;
    end
    check("done seen", {31'd0, got}, 32'd1);
  endtask

  task automatic expect_res(input string name, input logic [W-1:0] s, input logic c,
                            input logic o);
    check(name, {14'd0, Ovf, Cout, S}, {14'd0, o, c, s});
  endtask

  initial begin
    int bc, nd;
    #2 rst = 1'b1;
    #1 check("reset outputs", {13'd0, S, Cout, Ovf, busy, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, bc);
    check("busy cycles ffff+1", bc, NS);
    expect_res("ffff+1", 16'h0000, 1'b1, 1'b0);

    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, bc);
    expect_res("7fff+1", 16'h8000, 1'b0, 1'b1);

    op(16'h0005, 16'h0007, 1'b1, 1'b1, bc);
    expect_res("5-7", 16'hFFFE, 1'b0, 1'b0);

    // Start pulsed during RUN must be ignored.
    @(posedge clk); #1;
    A = 16'h1234; B = 16'h1111; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(bc);
    expect_res("1234+1111 busy start", 16'h2345, 1'b0, 1'b0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done) nd++; end
    check("no second done", nd, 0);

    // Asynchronous reset in the second RUN cycle.
    @(posedge clk); #1;
    A = 16'h00FF; B = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    #1 check("mid-run reset", {13'd0, S, Cout, Ovf, busy, done}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done) nd++; end
    check("no done after reset", nd, 0);
    op(16'h0002, 16'h0003, 1'b0, 1'b0, bc);
    expect_res("2+3 after reset", 16'h0005, 1'b0, 1'b0);

    // Back-to-back: start held in the DONE cycle.
    op(16'h0001, 16'h0001, 1'b0, 1'b0, bc);
    A = 16'h8000; B = 16'h8000; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy right after DONE", {31'd0, busy}, 32'd1);
    wait_done(bc);
    check("busy cycles back-to-back", bc, NS);
    expect_res("8000+8000", 16'h0000, 1'b1, 1'b1);

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 199) == 0);
      start = $urandom_range(0, 1);
      A     = W'($urandom);
      B     = W'($urandom);
      Cin   = $urandom_range(0, 1);
      Sub   = $urandom_range(0, 1);
    end
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
